// File: rtl/console_tx_arbiter.sv
// console_tx_arbiter
// Round-robin arbiter that shares one 8-byte UART transmitter among three
// requesters (0: console responses, 1: SPI reports, 2: I2C reports). The
// winner's payload is latched, a launch pulse is issued, and the transmitter
// busy flag is tracked to completion before per-port done is returned.
module console_tx_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     req,
  input  logic [191:0]   req_bytes,
  input  logic [11:0]    req_num,
  output logic [2:0]     ack,
  output logic [2:0]     done,
  output logic [2:0]     err,
  output logic [63:0]    tx_bytes,
  output logic [3:0]     tx_bytes_num,
  output logic           tx_pulse,
  input  logic           tx_busy,
  output logic           busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_LAUNCH     = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_r_q;
  logic [2:0]       ack_q, ack_d;
  logic [2:0]       done_q, done_d;
  logic [2:0]       err_q, err_d;
  logic             pulse_q, pulse_d;
  logic [63:0]      bytes_q, bytes_d;
  logic [3:0]       num_q, num_d;

  logic [1:0]       pick;
  logic [63:0]      sel_bytes;
  logic [3:0]       sel_num;
  logic             sel_legal;

  // Successor of a port index in the round-robin ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ring_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // One-hot per-port strobe for a port index.
  function automatic logic [2:0] port_hot(input logic [1:0] p);
    return 3'(3'b001 << p);
  endfunction

  // Round-robin pick: examine last+1, last+2, last+3 (mod 3); first requester wins.
  always_comb begin
    logic [1:0] c0, c1, c2;
    c0   = ring_next(last_q);
    c1   = ring_next(c0);
    c2   = ring_next(c1);
    pick = c2;
    if (req[c0])      pick = c0;
    else if (req[c1]) pick = c1;
    else              pick = c2;
  end

  // Slice the picked port's payload and byte count, and judge the count legal (1..8).
  always_comb begin
    sel_bytes = req_bytes[63:0];
    sel_num   = req_num[3:0];
    case (pick)
      2'd1: begin
        sel_bytes = req_bytes[127:64];
        sel_num   = req_num[7:4];
      end
      2'd2: begin
        sel_bytes = req_bytes[191:128];
        sel_num   = req_num[11:8];
      end
      default: begin
        sel_bytes = req_bytes[63:0];
        sel_num   = req_num[3:0];
      end
    endcase
    sel_legal = (sel_num != 4'd0) && (sel_num <= 4'd8);
  end

  // Next-state logic for the arbitration / launch / completion sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ack_d   = 3'b000;
    done_d  = 3'b000;
    err_d   = 3'b000;
    pulse_d = 1'b0;
    bytes_d = bytes_q;
    num_d   = num_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d = pick;
          if (sel_legal) begin
            // Acknowledge and launch are presented together in the LAUNCH cycle.
            state_d = S_LAUNCH;
            ack_d   = port_hot(pick);
            pulse_d = 1'b1;
            bytes_d = sel_bytes;
            num_d   = sel_num;
          end else begin
            // Rejected requests still consume the port's round-robin turn.
            err_d  = port_hot(pick);
            last_d = pick;
          end
        end
      end
      S_LAUNCH: begin
        last_d  = win_q;
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never reported busy; close the job anyway.
          done_d  = port_hot(win_q);
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (busy_r_q && !tx_busy) begin
          done_d  = port_hot(win_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, control and latched-payload registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= 2'd2;
      win_q    <= 2'd0;
      cnt_q    <= '0;
      busy_r_q <= 1'b0;
      ack_q    <= 3'b000;
      done_q   <= 3'b000;
      err_q    <= 3'b000;
      pulse_q  <= 1'b0;
      bytes_q  <= 64'd0;
      num_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      busy_r_q <= tx_busy;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
      bytes_q  <= bytes_d;
      num_q    <= num_d;
    end
  end

  assign ack          = ack_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tx_pulse     = pulse_q;
  assign tx_bytes     = bytes_q;
  assign tx_bytes_num = num_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_console_tx_arbiter.sv
// Directed bench for console_tx_arbiter: reset values, single job with payload
// hold, simultaneous round-robin, illegal byte counts, start timeout and
// reset in the middle of a job.
module tb_console_tx_arbiter;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     req;
  logic [191:0]   req_bytes;
  logic [11:0]    req_num;
  logic [2:0]     ack, done, err;
  logic [63:0]    tx_bytes;
  logic [3:0]     tx_bytes_num;
  logic           tx_pulse;
  logic           tx_busy;
  logic           busy;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] P0 = 64'h0000_0000_4F4B_0D0A;
  localparam logic [63:0] P1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] P2 = 64'hA1A2_A3A4_A5A6_A7A8;
  localparam logic [63:0] PX = 64'hDEAD_BEEF_CAFE_F00D;

  always #5 clk = ~clk;

  console_tx_arbiter #(.START_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_bytes    (req_bytes),
    .req_num      (req_num),
    .ack          (ack),
    .done         (done),
    .err          (err),
    .tx_bytes     (tx_bytes),
    .tx_bytes_num (tx_bytes_num),
    .tx_pulse     (tx_pulse),
    .tx_busy      (tx_busy),
    .busy         (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  64'(ack), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"},  64'(err), 64'd0);
    check({tag, "_pls"},  64'(tx_pulse), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_txb"},  tx_bytes, 64'd0);
    check({tag, "_txn"},  64'(tx_bytes_num), 64'd0);
  endtask

  // Called in the LAUNCH cycle: raise tx_busy, hold it, drop it, expect done.
  task automatic run_to_done(input logic [2:0] exp_done, input int nhigh);
    tx_busy = 1'b1;
    repeat (2 + nhigh) begin
      tick;
      check("job_nodone", 64'(done), 64'd0);
    end
    tx_busy = 1'b0;
    tick;
    check("job_done", 64'(done), 64'(exp_done));
    check("job_idle", 64'(busy), 64'd0);
    check("job_noack", 64'(ack), 64'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
  endtask

  initial begin
    reset     = 1'b1;
    req       = 3'b000;
    req_bytes = {P2, P1, P0};
    req_num   = {4'd5, 4'd3, 4'd4};
    tx_busy   = 1'b0;
    tick;
    tick;
    check_all_zero("rst");
    reset = 1'b0;
    tick;
    check("post_rst_busy", 64'(busy), 64'd0);

    // Single request from port 0 with payload change after ack.
    req = 3'b001;
    tick;
    check("s_ack", 64'(ack), 64'h1);
    check("s_pulse", 64'(tx_pulse), 64'h1);
    check("s_num", 64'(tx_bytes_num), 64'd4);
    check("s_bytes", tx_bytes, P0);
    check("s_busy", 64'(busy), 64'h1);
    req = 3'b000;
    tick;
    check("s_ack_off", 64'(ack), 64'd0);
    check("s_pulse_off", 64'(tx_pulse), 64'd0);
    req_bytes[63:0] = PX;
    tick;
    tx_busy = 1'b1;
    repeat (40) begin
      tick;
      check("s_nodone", 64'(done), 64'd0);
      check("s_hold", tx_bytes, P0);
    end
    tx_busy = 1'b0;
    tick;
    check("s_done", 64'(done), 64'h1);
    check("s_hold_done", tx_bytes, P0);
    check("s_idle", 64'(busy), 64'd0);
    tick;
    check("s_done_off", 64'(done), 64'd0);
    check("s_hold_after", tx_bytes, P0);
    req_bytes[63:0] = P0;

    // Simultaneous requests from reset: order 0, 1, then 2 ahead of re-requesting 0.
    do_reset;
    req = 3'b111;
    tick;
    check("rr_ack0", 64'(ack), 64'h1);
    check("rr_bytes0", tx_bytes, P0);
    req[0] = 1'b0;
    run_to_done(3'b001, 3);
    tick;
    check("rr_ack1", 64'(ack), 64'h2);
    check("rr_num1", 64'(tx_bytes_num), 64'd3);
    check("rr_bytes1", tx_bytes, P1);
    req[1] = 1'b0;
    req[0] = 1'b1;
    run_to_done(3'b010, 2);
    tick;
    check("rr_ack2", 64'(ack), 64'h4);
    check("rr_num2", 64'(tx_bytes_num), 64'd5);
    check("rr_bytes2", tx_bytes, P2);
    req[2] = 1'b0;
    run_to_done(3'b100, 1);
    tick;
    check("rr_ack0b", 64'(ack), 64'h1);
    req = 3'b000;
    run_to_done(3'b001, 0);

    // Illegal byte counts on port 1: 0 then 9.
    req_num[7:4] = 4'd0;
    req = 3'b010;
    tick;
    check("il0_err", 64'(err), 64'h2);
    check("il0_ack", 64'(ack), 64'd0);
    check("il0_pulse", 64'(tx_pulse), 64'd0);
    check("il0_busy", 64'(busy), 64'd0);
    req = 3'b000;
    tick;
    check("il0_err_off", 64'(err), 64'd0);
    req_num[7:4] = 4'd9;
    req = 3'b010;
    tick;
    check("il9_err", 64'(err), 64'h2);
    check("il9_ack", 64'(ack), 64'd0);
    check("il9_pulse", 64'(tx_pulse), 64'd0);
    req = 3'b000;
    tick;
    check("il9_err_off", 64'(err), 64'd0);
    req_num[7:4] = 4'd3;
    req = 3'b011;
    tick;
    check("il_last_moved", 64'(ack), 64'h1);
    req = 3'b000;
    run_to_done(3'b001, 1);

    // Start timeout on port 2.
    req = 3'b100;
    tick;
    check("to_ack", 64'(ack), 64'h4);
    req = 3'b000;
    tick;
    repeat (15) begin
      tick;
      check("to_nodone", 64'(done), 64'd0);
      check("to_busy", 64'(busy), 64'h1);
    end
    tick;
    check("to_done", 64'(done), 64'h4);
    check("to_idle", 64'(busy), 64'd0);
    tick;
    check("to_done_off", 64'(done), 64'd0);

    // Reset during WAIT_DONE.
    req = 3'b010;
    tick;
    check("rm_ack", 64'(ack), 64'h2);
    req = 3'b000;
    tx_busy = 1'b1;
    tick;
    tick;
    tick;
    check("rm_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    check_all_zero("rm");
    tx_busy = 1'b0;
    tick;
    check("rm_nodone", 64'(done), 64'd0);
    check("rm_idle", 64'(busy), 64'd0);
    reset = 1'b0;
    tick;
    check("rm_nodone2", 64'(done), 64'd0);
    req = 3'b111;
    tick;
    check("rm_first_port0", 64'(ack), 64'h1);
    req = 3'b000;
    run_to_done(3'b001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
